// File: rtl/ex_md.sv
// ex_md: execute-stage ALU with an iterative multiply/divide unit.
//
// Single-cycle logic/shift/arithmetic results are combinational. MULT/MULTU
// use shift-add and DIV/DIVU use restoring division, one step per cycle for
// WIDTH cycles, writing HI/LO on the last step.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   valid_i           an instruction is present in EX
//   aluop_i           operation code
//   reg1_i, reg2_i    operands rs, rt
//   wd_i, wreg_i      destination GPR and its write request
//   flush_i           kill the in-flight instruction / abort mult-div
//   wd_o, wreg_o      destination GPR and write enable
//   wdata_o           GPR write data
//   ovf_o             signed overflow on ADD/SUB
//   stall_o           hold ID/EX and upstream stages
//   hi_o, lo_o        architectural HI/LO registers
module ex_md #(
    parameter int WIDTH      = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [4:0]            aluop_i,
    input  logic [WIDTH-1:0]      reg1_i,
    input  logic [WIDTH-1:0]      reg2_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic                  flush_i,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic [WIDTH-1:0]      wdata_o,
    output logic                  ovf_o,
    output logic                  stall_o,
    output logic [WIDTH-1:0]      hi_o,
    output logic [WIDTH-1:0]      lo_o
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [4:0] OP_AND   = 5'd1;
    localparam logic [4:0] OP_OR    = 5'd2;
    localparam logic [4:0] OP_XOR   = 5'd3;
    localparam logic [4:0] OP_NOR   = 5'd4;
    localparam logic [4:0] OP_SLL   = 5'd5;
    localparam logic [4:0] OP_SRL   = 5'd6;
    localparam logic [4:0] OP_SRA   = 5'd7;
    localparam logic [4:0] OP_ADD   = 5'd8;
    localparam logic [4:0] OP_ADDU  = 5'd9;
    localparam logic [4:0] OP_SUB   = 5'd10;
    localparam logic [4:0] OP_SUBU  = 5'd11;
    localparam logic [4:0] OP_SLT   = 5'd12;
    localparam logic [4:0] OP_SLTU  = 5'd13;
    localparam logic [4:0] OP_MFHI  = 5'd14;
    localparam logic [4:0] OP_MFLO  = 5'd15;
    localparam logic [4:0] OP_MTHI  = 5'd16;
    localparam logic [4:0] OP_MTLO  = 5'd17;
    localparam logic [4:0] OP_MULT  = 5'd18;
    localparam logic [4:0] OP_MULTU = 5'd19;
    localparam logic [4:0] OP_DIV   = 5'd20;
    localparam logic [4:0] OP_DIVU  = 5'd21;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;       // mult: {partial, multiplier}; div: {remainder, dividend/quotient}
    logic [WIDTH-1:0]   opnd_q, opnd_d;     // multiplicand or divisor magnitude
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;       // product/quotient must be negated
    logic               rem_neg_q, rem_neg_d;
    logic               div_zero_q, div_zero_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               md_op, signed_op, issue, stall_int, mt_en;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum, div_sh, div_diff;
    logic [2*WIDTH-1:0] mul_next, div_next, step, prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;
    logic [WIDTH-1:0]   add_res, sub_res, res;
    logic               add_ovf, sub_ovf, ovf_int, single_op;
    logic [SHW-1:0]     shamt;

    // ---------------- mult/div datapath ----------------
    always_comb begin
        md_op     = (aluop_i >= OP_MULT) && (aluop_i <= OP_DIVU);
        signed_op = (aluop_i == OP_MULT) || (aluop_i == OP_DIV);
        stall_int = ((state_q == ST_IDLE) && valid_i && md_op && !flush_i) || (state_q == ST_BUSY);
        issue     = (state_q == ST_IDLE) && valid_i && md_op && !flush_i;
        mt_en     = valid_i && !flush_i && !stall_int && ((aluop_i == OP_MTHI) || (aluop_i == OP_MTLO));
        a_neg     = signed_op && reg1_i[WIDTH-1];
        b_neg     = signed_op && reg2_i[WIDTH-1];
        mag_a     = a_neg ? -reg1_i : reg1_i;
        mag_b     = b_neg ? -reg2_i : reg2_i;

        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};

        // Restoring step: shift in the next dividend bit, keep the difference if no borrow.
        div_sh    = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff  = div_sh - {1'b0, opnd_q};
        div_next  = div_diff[WIDTH] ? {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        step      = is_div_q ? div_next : mul_next;

        // Divide by zero leaves rem = |dividend|, so sign correction restores the dividend in HI.
        prod_fix  = neg_q ? -step : step;
        quot_fix  = div_zero_q ? '1 : (neg_q ? -step[WIDTH-1:0] : step[WIDTH-1:0]);
        rem_fix   = rem_neg_q ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        is_div_d   = is_div_q;
        neg_d      = neg_q;
        rem_neg_d  = rem_neg_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (issue) begin
                    state_d    = ST_BUSY;
                    cnt_d      = CW'(WIDTH);
                    acc_d      = {{WIDTH{1'b0}}, mag_a};
                    opnd_d     = mag_b;
                    is_div_d   = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);
                    neg_d      = a_neg ^ b_neg;
                    rem_neg_d  = a_neg;
                    div_zero_d = (reg2_i == '0);
                end else if (mt_en) begin
                    if (aluop_i == OP_MTHI) hi_d = reg1_i;
                    else                    lo_d = reg1_i;
                end
            end
            ST_BUSY: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = step;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_d = ST_DONE;
                        hi_d    = is_div_q ? rem_fix  : prod_fix[2*WIDTH-1:WIDTH];
                        lo_d    = is_div_q ? quot_fix : prod_fix[WIDTH-1:0];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            is_div_q   <= is_div_d;
            neg_q      <= neg_d;
            rem_neg_q  <= rem_neg_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    // ---------------- single-cycle datapath ----------------
    always_comb begin
        shamt   = reg1_i[SHW-1:0];
        add_res = reg1_i + reg2_i;
        sub_res = reg1_i - reg2_i;
        add_ovf = (reg1_i[WIDTH-1] == reg2_i[WIDTH-1]) && (add_res[WIDTH-1] != reg1_i[WIDTH-1]);
        sub_ovf = (reg1_i[WIDTH-1] != reg2_i[WIDTH-1]) && (sub_res[WIDTH-1] != reg1_i[WIDTH-1]);
        res     = '0;
        case (aluop_i)
            OP_AND:  res = reg1_i & reg2_i;
            OP_OR:   res = reg1_i | reg2_i;
            OP_XOR:  res = reg1_i ^ reg2_i;
            OP_NOR:  res = ~(reg1_i | reg2_i);
            OP_SLL:  res = reg2_i << shamt;
            OP_SRL:  res = reg2_i >> shamt;
            OP_SRA:  res = $unsigned($signed(reg2_i) >>> shamt);
            OP_ADD,
            OP_ADDU: res = add_res;
            OP_SUB,
            OP_SUBU: res = sub_res;
            OP_SLT:  res[0] = $signed(reg1_i) < $signed(reg2_i);
            OP_SLTU: res[0] = reg1_i < reg2_i;
            OP_MFHI: res = hi_q;
            OP_MFLO: res = lo_q;
            default: res = '0;
        endcase
        single_op = (aluop_i >= OP_AND) && (aluop_i <= OP_MFLO);
        ovf_int   = valid_i && (((aluop_i == OP_ADD) && add_ovf) || ((aluop_i == OP_SUB) && sub_ovf));

        // Outputs are forced low combinationally while reset is held.
        wd_o    = rst ? '0 : wd_i;
        wdata_o = rst ? '0 : res;
        ovf_o   = !rst && ovf_int;
        stall_o = !rst && stall_int;
        wreg_o  = !rst && single_op && wreg_i && valid_i && !flush_i && !stall_int && !ovf_int;
        hi_o    = hi_q;
        lo_o    = lo_q;
    end

endmodule

// File: tb/tb_ex_md.sv
// tb_ex_md: self-checking bench for ex_md (WIDTH=32). Single-cycle ops are
// applied from a vector table; mult/div, flush and reset are hand sequences.
// Expected results travel through scoreboard queues.
module tb_ex_md;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_i;
    logic [4:0]    aluop_i;
    logic [W-1:0]  reg1_i, reg2_i;
    logic [4:0]    wd_i;
    logic          wreg_i;
    logic          flush_i;
    logic [4:0]    wd_o;
    logic          wreg_o;
    logic [W-1:0]  wdata_o;
    logic          ovf_o;
    logic          stall_o;
    logic [W-1:0]  hi_o, lo_o;

    ex_md #(.WIDTH(W), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .aluop_i(aluop_i),
        .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .flush_i(flush_i), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .ovf_o(ovf_o), .stall_o(stall_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         wr;
        logic [W-1:0] wdata;
        logic         wreg;
        logic         ovf;
    } vec_t;

    typedef struct {
        logic [W-1:0] wdata;
        logic         wreg;
        logic         ovf;
    } alu_exp_t;

    typedef struct {
        string        name;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } md_exp_t;

    vec_t     vecs [20];
    alu_exp_t sb_alu[$];
    md_exp_t  sb_md[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic fl);
        valid_i = v;
        aluop_i = op;
        reg1_i  = a;
        reg2_i  = b;
        flush_i = fl;
    endtask

    task automatic run_md(input string name, input logic [4:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] ehi, input logic [W-1:0] elo);
        int n;
        logic wbad;
        md_exp_t e;
        sb_md.push_back('{name, ehi, elo});
        @(posedge clk); #1;
        drive(1'b1, op, a, b, 1'b0);
        #2;
        n = 0;
        wbad = 1'b0;
        while (stall_o === 1'b1 && n < 200) begin
            if (wreg_o !== 1'b0) wbad = 1'b1;
            n++;
            @(posedge clk); #2;
        end
        e = sb_md.pop_front();
        chk({e.name, " stall cycles"}, 64'(n), 64'd33);
        chk({e.name, " wreg low"}, {63'd0, wbad}, 64'd0);
        chk({e.name, " hi"}, {32'd0, hi_o}, {32'd0, e.hi});
        chk({e.name, " lo"}, {32'd0, lo_o}, {32'd0, e.lo});
        chk({e.name, " done stall"}, {63'd0, stall_o}, 64'd0);
        // Inputs stay held through DONE, then the next instruction arrives.
        @(posedge clk); #1;
        drive(1'b0, 5'd0, '0, '0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        alu_exp_t ea;
        logic [W-1:0] hi_save, lo_save;

        //          op     a             b             wr    wdata         wreg  ovf
        vecs[0]  = '{5'd1,  32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 32'hF000F000, 1'b1, 1'b0};
        vecs[1]  = '{5'd2,  32'hF0F0F0F0, 32'h0F0F0000, 1'b1, 32'hFFFFF0F0, 1'b1, 1'b0};
        vecs[2]  = '{5'd3,  32'hFFFF0000, 32'h0F0F0F0F, 1'b1, 32'hF0F00F0F, 1'b1, 1'b0};
        vecs[3]  = '{5'd4,  32'h0000FFFF, 32'h00FF0000, 1'b1, 32'hFF000000, 1'b1, 1'b0};
        vecs[4]  = '{5'd5,  32'h00000004, 32'h000000F1, 1'b1, 32'h00000F10, 1'b1, 1'b0};
        vecs[5]  = '{5'd6,  32'h00000004, 32'h80000000, 1'b1, 32'h08000000, 1'b1, 1'b0};
        vecs[6]  = '{5'd7,  32'h00000004, 32'h80000000, 1'b1, 32'hF8000000, 1'b1, 1'b0};
        vecs[7]  = '{5'd7,  32'h00000024, 32'h70000000, 1'b1, 32'h07000000, 1'b1, 1'b0};
        vecs[8]  = '{5'd8,  32'h7FFFFFFF, 32'h00000001, 1'b1, 32'h80000000, 1'b0, 1'b1};
        vecs[9]  = '{5'd9,  32'h7FFFFFFF, 32'h00000001, 1'b1, 32'h80000000, 1'b1, 1'b0};
        vecs[10] = '{5'd10, 32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b1};
        vecs[11] = '{5'd11, 32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b0};
        vecs[12] = '{5'd12, 32'hFFFFFFFF, 32'h00000001, 1'b1, 32'h00000001, 1'b1, 1'b0};
        vecs[13] = '{5'd13, 32'hFFFFFFFF, 32'h00000001, 1'b1, 32'h00000000, 1'b1, 1'b0};
        vecs[14] = '{5'd8,  32'h00000005, 32'hFFFFFFFD, 1'b1, 32'h00000002, 1'b1, 1'b0};
        vecs[15] = '{5'd1,  32'hFFFFFFFF, 32'h12345678, 1'b0, 32'h12345678, 1'b0, 1'b0};
        vecs[16] = '{5'd0,  32'h00000001, 32'h00000002, 1'b1, 32'h00000000, 1'b0, 1'b0};
        vecs[17] = '{5'd25, 32'h00000001, 32'h00000002, 1'b1, 32'h00000000, 1'b0, 1'b0};
        vecs[18] = '{5'd10, 32'h00000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[19] = '{5'd8,  32'h80000000, 32'h80000000, 1'b1, 32'h00000000, 1'b0, 1'b1};

        // Reset held from time zero with an overflowing ADD on the inputs.
        rst = 1'b1;
        wd_i = 5'd7;
        wreg_i = 1'b1;
        drive(1'b1, 5'd8, 32'h7FFFFFFF, 32'h1, 1'b0);
        #3;
        chk("rst wd_o", {59'd0, wd_o}, 64'd0);
        chk("rst wreg_o", {63'd0, wreg_o}, 64'd0);
        chk("rst wdata_o", {32'd0, wdata_o}, 64'd0);
        chk("rst ovf_o", {63'd0, ovf_o}, 64'd0);
        chk("rst stall_o", {63'd0, stall_o}, 64'd0);
        chk("rst hi/lo", {hi_o, lo_o}, 64'd0);
        #10 rst = 1'b0;
        drive(1'b0, 5'd0, '0, '0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            sb_alu.push_back('{vecs[i].wdata, vecs[i].wreg, vecs[i].ovf});
            @(posedge clk); #1;
            wreg_i = vecs[i].wr;
            drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
            #2;
            ea = sb_alu.pop_front();
            chk($sformatf("vec%0d wdata", i), {32'd0, wdata_o}, {32'd0, ea.wdata});
            chk($sformatf("vec%0d wreg", i), {63'd0, wreg_o}, {63'd0, ea.wreg});
            chk($sformatf("vec%0d ovf", i), {63'd0, ovf_o}, {63'd0, ea.ovf});
            chk($sformatf("vec%0d wd", i), {59'd0, wd_o}, 64'd7);
            chk($sformatf("vec%0d stall", i), {63'd0, stall_o}, 64'd0);
        end
        wreg_i = 1'b1;

        run_md("mult -3x5", 5'd18, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
        @(posedge clk); #1;
        drive(1'b1, 5'd15, '0, '0, 1'b0);
        #2;
        chk("mflo data", {32'd0, wdata_o}, 64'hFFFFFFF1);
        chk("mflo wreg", {63'd0, wreg_o}, 64'd1);
        @(posedge clk); #1;
        drive(1'b1, 5'd14, '0, '0, 1'b0);
        #2;
        chk("mfhi data", {32'd0, wdata_o}, 64'hFFFFFFFF);

        run_md("multu max", 5'd19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run_md("div -7/2", 5'd20, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_md("divu 7/0", 5'd21, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF);
        run_md("div min/-1", 5'd20, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
        run_md("div -7/0", 5'd20, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF);
        run_md("div 100/-7", 5'd20, 32'd100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFF2);

        // MTHI / MTLO
        @(posedge clk); #1;
        drive(1'b1, 5'd16, 32'h1234, '0, 1'b0);
        #2;
        chk("mthi wreg", {63'd0, wreg_o}, 64'd0);
        @(posedge clk); #1;
        chk("mthi hi", {32'd0, hi_o}, 64'h1234);
        drive(1'b1, 5'd17, 32'h5678, '0, 1'b0);
        @(posedge clk); #1;
        chk("mtlo lo", {32'd0, lo_o}, 64'h5678);
        hi_save = 32'h1234;
        lo_save = 32'h5678;

        // MULTU aborted by flush in BUSY cycle 5.
        drive(1'b1, 5'd19, 32'd2, 32'd3, 1'b0);
        #2;
        chk("flush issue stall", {63'd0, stall_o}, 64'd1);
        repeat (5) @(posedge clk);
        #1 flush_i = 1'b1;
        #1 chk("flush busy stall", {63'd0, stall_o}, 64'd1);
        @(posedge clk); #1;
        chk("flush stall drop", {63'd0, stall_o}, 64'd0);
        drive(1'b0, 5'd0, '0, '0, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        chk("flush hi kept", {32'd0, hi_o}, {32'd0, hi_save});
        chk("flush lo kept", {32'd0, lo_o}, {32'd0, lo_save});
        chk("flush idle stall", {63'd0, stall_o}, 64'd0);

        // Flush coincident with issue, and with MTLO.
        drive(1'b1, 5'd18, 32'd3, 32'd3, 1'b1);
        #2;
        chk("coinc stall", {63'd0, stall_o}, 64'd0);
        chk("coinc wreg", {63'd0, wreg_o}, 64'd0);
        @(posedge clk); #1;
        chk("coinc stall next", {63'd0, stall_o}, 64'd0);
        drive(1'b1, 5'd17, 32'hDEAD, '0, 1'b1);
        @(posedge clk); #1;
        drive(1'b0, 5'd0, '0, '0, 1'b0);
        #2;
        chk("coinc hi", {32'd0, hi_o}, {32'd0, hi_save});
        chk("coinc lo", {32'd0, lo_o}, {32'd0, lo_save});
        chk("coinc stall after", {63'd0, stall_o}, 64'd0);

        run_md("multu 2x3", 5'd19, 32'd2, 32'd3, 32'd0, 32'd6);

        // Asynchronous reset in BUSY cycle 10.
        @(posedge clk); #1;
        drive(1'b1, 5'd19, 32'h10, 32'h10, 1'b0);
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("busy rst stall", {63'd0, stall_o}, 64'd0);
        chk("busy rst hi/lo", {hi_o, lo_o}, 64'd0);
        chk("busy rst wdata", {32'd0, wdata_o}, 64'd0);
        chk("busy rst wd", {59'd0, wd_o}, 64'd0);
        drive(1'b0, 5'd0, '0, '0, 1'b0);
        #2 rst = 1'b0;
        repeat (40) @(posedge clk);
        #2;
        chk("post rst stall", {63'd0, stall_o}, 64'd0);
        chk("post rst hi/lo", {hi_o, lo_o}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_md.md
Name: ex_md

Overview:
- Parametrised execute-stage ALU for the MIPS pipeline. Sits between the ID/EX and EX/MEM registers.
- Adds to the single-cycle logic/shift/arith datapath:
  - iterative multiply/divide unit
  - architectural HI/LO registers
  - pipeline stall request
  - signed-overflow trap flag
- Single-cycle ops stay combinational. Mult/div are multi-cycle.

Parameters:
- WIDTH, 32, datapath width. Must be a power of 2 and ≥ 8.
- REG_ADDR_W, 5, GPR address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- valid_i  in  1  an instruction is present in EX this cycle.
- aluop_i  in  5  operation code (see Behaviour).
- reg1_i  in  WIDTH  operand rs.
- reg2_i  in  WIDTH  operand rt.
- wd_i  in  REG_ADDR_W  destination GPR.
- wreg_i  in  1  the instruction writes a GPR.
- flush_i  in  1  kill the in-flight instruction and abort mult/div.
- wd_o  out  REG_ADDR_W  destination GPR, passed through.
- wreg_o  out  1  GPR write enable.
- wdata_o  out  WIDTH  GPR write data.
- ovf_o  out  1  signed overflow on ADD/SUB; exception request.
- stall_o  out  1  hold the ID/EX register and all upstream stages.
- hi_o  out  WIDTH  current HI register.
- lo_o  out  WIDTH  current LO register.

Behaviour:
- Opcodes:
  - 0 NOP, 1 AND, 2 OR, 3 XOR, 4 NOR
  - 5 SLL, 6 SRL, 7 SRA
  - 8 ADD, 9 ADDU, 10 SUB, 11 SUBU, 12 SLT, 13 SLTU
  - 14 MFHI, 15 MFLO, 16 MTHI, 17 MTLO
  - 18 MULT, 19 MULTU, 20 DIV, 21 DIVU
  - 22-31 are NOP.
- Shifts: value is reg2_i; shift amount is reg1_i[log2(WIDTH)-1:0].
- SLT/SLTU: result is 1 or 0, zero-extended to WIDTH.
- Single-cycle ops (1-15) are combinational, zero latency:
  - wd_o = wd_i.
  - wreg_o = wreg_i & valid_i & ~flush_i & ~stall_o & ~ovf_o.
  - wdata_o = result; 0 for NOP/unknown.
- ovf_o = 1 only for ADD/SUB with valid_i, when the signed result overflows WIDTH. Otherwise 0. ADDU/SUBU never flag.
- MTHI/MTLO write HI/LO from reg1_i at the clock edge when valid_i & ~flush_i & ~stall_o. wreg_o = 0 for these ops.
- Mult/div never write a GPR: wreg_o = 0 throughout.
- FSM states:
  - IDLE -> BUSY: valid_i & op in 18..21 & ~flush_i.
    - Latch operands and op.
    - Signed ops: latch magnitudes and result-sign bits.
    - Iteration count = WIDTH.
  - BUSY: one shift-add or restoring-subtract step per cycle, for WIDTH cycles.
    - On the last step, write the sign-corrected result to HI/LO, then go to DONE.
  - DONE: stall_o = 0 for exactly one cycle, so upstream advances past the mult/div. Then -> IDLE.
- stall_o = (IDLE & valid_i & mult/div op & ~flush_i) | BUSY. It is high for exactly WIDTH+1 consecutive cycles per mult/div.
- Results:
  - MULT/MULTU: {HI,LO} = 2*WIDTH-bit product.
  - DIV/DIVU: LO = quotient truncated toward zero; HI = remainder, with the sign of the dividend.
  - Divide by zero: LO = all-ones, HI = dividend. Full latency still applies.
  - Signed most-negative / -1: LO = most-negative, HI = 0.
- flush_i:
  - In BUSY or DONE: next state IDLE, HI/LO unchanged.
  - In IDLE: suppresses issue, MTHI/MTLO and wreg_o.
- Upstream holds inputs stable while stall_o = 1. Input changes during BUSY are ignored.
- Reset: while rst = 1, asynchronously:
  - state = IDLE; HI = LO = 0; internal counters and accumulators = 0.
  - wd_o = 0, wreg_o = 0, wdata_o = 0, ovf_o = 0, stall_o = 0.
  - Reset mid-BUSY discards the operation.

Test Plan:
- Reset:
  - rst pulse asynchronous to clk -> all outputs 0 immediately; hi_o = lo_o = 0.
  - Assert rst in BUSY cycle 10 -> stall_o drops without a clk edge; after release, HI/LO = 0.
- Logic/shift:
  - AND 0xF0F0F0F0,0xFF00FF00 -> wdata_o = 0xF000F000, wreg_o = wreg_i.
  - SRA reg1 = 4, reg2 = 0x80000000 -> 0xF8000000.
  - SLT 0xFFFFFFFF,1 -> 1.
  - SLTU 0xFFFFFFFF,1 -> 0.
- Overflow:
  - ADD 0x7FFFFFFF + 1 -> ovf_o = 1, wreg_o = 0.
  - ADDU same operands -> wdata_o = 0x80000000, ovf_o = 0, wreg_o = 1.
- MULT:
  - MULT -3 × 5 -> stall_o high 33 cycles, then 1 DONE cycle; then hi_o = 0xFFFFFFFF, lo_o = 0xFFFFFFF1.
  - MFLO next -> wdata_o = 0xFFFFFFF1.
- DIV:
  - DIV -7/2 -> lo_o = 0xFFFFFFFD, hi_o = 0xFFFFFFFF.
  - DIVU 7/0 -> lo_o = 0xFFFFFFFF, hi_o = 7, same 33-cycle stall.
- Flush:
  - MTHI 0x1234 first -> hi_o = 0x1234.
  - Then MULTU 2×3, flush_i in BUSY cycle 5 -> stall_o low the next cycle; HI/LO still 0x1234 / previous LO.
  - Flush coincident with issue -> no stall, no state change.
